// File: rtl/fifo_pkg.sv
// Shared types and pointer-coding helpers for the async FIFO write and read controllers.
package fifo_pkg;

  typedef enum logic {
    INIT,
    RUN
  } wr_state_e;

  localparam int INIT_CYCLES = 2;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i + 1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync2.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module ptr_sync2 #(
  parameter int WIDTH = 5
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] rq1_q, rq1_d;
  logic [WIDTH-1:0] rq2_q, rq2_d;

  always_comb begin
    rq1_d = rst ? '0 : d_in;
    rq2_d = rst ? '0 : rq1_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    rq1_q <= rq1_d;
    rq2_q <= rq2_d;
  end

  assign q_out = rq2_q;

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: binary/Gray write pointer, full and
// almost-full flags against the synchronized read pointer, and a sticky overflow flag.
module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic                  Clk,
  input  logic                  rst,
  input  logic                  wr_req_in,
  input  logic [ADDR_WIDTH:0]   rd_gray_ptr_in,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [ADDR_WIDTH:0]   wr_gray_ptr_out,
  output logic                  full_out,
  output logic                  almost_full_out,
  output logic [ADDR_WIDTH:0]   level_out,
  output logic                  overflow_out
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(INIT_CYCLES + 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);

  wr_state_e state_q, state_d;
  logic [CW-1:0] init_cnt_q, init_cnt_d;
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;

  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] occ_next;
  logic          full_cmp;
  logic          afull_cmp;

  ptr_sync2 #(.WIDTH(PW)) u_rd_sync (
    .Clk   (Clk),
    .rst   (rst),
    .d_in  (rd_gray_ptr_in),
    .q_out (rq2)
  );

  assign wr_en_out  = wr_req_in & ~full_q & (state_q == RUN);
  assign wbin_next  = wbin_q + PW'(wr_en_out);
  assign wgray_next = PW'(bin2gray(32'(wbin_next)));
  assign rbin       = PW'(gray2bin(32'(rq2)));
  assign occ_next   = wbin_next - rbin;

  // Full when the next write pointer laps the read pointer: top two Gray bits inverted.
  assign full_cmp  = (wgray_next == {~rq2[PW-1 -: 2], rq2[PW-3:0]});
  assign afull_cmp = (int'(occ_next) >= AFULL_THRESH);

  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wbin_d     = wbin_q;
    wgray_d    = wgray_q;
    full_d     = full_q;
    afull_d    = afull_q;
    ovf_d      = ovf_q;

    if (rst) begin
      state_d    = INIT;
      init_cnt_d = '0;
      wbin_d     = '0;
      wgray_d    = '0;
      full_d     = 1'b1;
      afull_d    = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          full_d  = 1'b1;
          afull_d = 1'b0;
          // Flags take their first real value on the edge that enters RUN.
          if (init_cnt_q == INIT_LAST) begin
            state_d = RUN;
            full_d  = full_cmp;
            afull_d = afull_cmp;
          end else begin
            init_cnt_d = init_cnt_q + 1'b1;
          end
        end
        RUN: begin
          wbin_d  = wbin_next;
          wgray_d = wgray_next;
          full_d  = full_cmp;
          afull_d = afull_cmp;
          if (wr_req_in && full_q) begin
            ovf_d = 1'b1;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    state_q    <= state_d;
    init_cnt_q <= init_cnt_d;
    wbin_q     <= wbin_d;
    wgray_q    <= wgray_d;
    full_q     <= full_d;
    afull_q    <= afull_d;
    ovf_q      <= ovf_d;
  end

  assign wr_addr_out     = wbin_q[ADDR_WIDTH-1:0];
  assign wr_gray_ptr_out = wgray_q;
  assign full_out        = full_q;
  assign almost_full_out = afull_q;
  assign level_out       = wbin_q - rbin;
  assign overflow_out    = ovf_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl: expected write addresses go into a queue that a
// monitor drains on every write strobe, while the stimulus thread checks flags and pointers.
module tb_async_fifo_wr_ctrl;

  logic       Clk;
  logic       rst;
  logic       wr_req_in;
  logic [4:0] rd_gray_ptr_in;
  logic       wr_en_out;
  logic [3:0] wr_addr_out;
  logic [4:0] wr_gray_ptr_out;
  logic       full_out;
  logic       almost_full_out;
  logic [4:0] level_out;
  logic       overflow_out;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  logic [3:0] exp_addr_q[$];
  logic       gray_chk_en = 1'b0;
  logic [4:0] prev_gray = '0;

  async_fifo_wr_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(14)) dut (
    .Clk             (Clk),
    .rst             (rst),
    .wr_req_in       (wr_req_in),
    .rd_gray_ptr_in  (rd_gray_ptr_in),
    .wr_en_out       (wr_en_out),
    .wr_addr_out     (wr_addr_out),
    .wr_gray_ptr_out (wr_gray_ptr_out),
    .full_out        (full_out),
    .almost_full_out (almost_full_out),
    .level_out       (level_out),
    .overflow_out    (overflow_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: every write strobe outside reset must carry the next expected address.
  initial begin
    forever begin
      @(negedge Clk);
      if (wr_en_out === 1'b1 && rst === 1'b0) begin
        pulse_cnt++;
        if (exp_addr_q.size() == 0) check("unexpected_wr_en", 32'd1, 32'd0);
        else check("wr_addr", 32'(wr_addr_out), 32'(exp_addr_q.pop_front()));
      end
      if (gray_chk_en) begin
        if (wr_gray_ptr_out !== prev_gray)
          check("gray_one_bit", 32'($countones(wr_gray_ptr_out ^ prev_gray)), 32'd1);
        prev_gray = wr_gray_ptr_out;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] wb;
    int k_sat;

    rst = 1'b1;
    wr_req_in = 1'b0;
    rd_gray_ptr_in = '0;

    // Reset for 3 cycles
    repeat (3) step();
    check("rst_gray", 32'(wr_gray_ptr_out), 32'd0);
    check("rst_addr", 32'(wr_addr_out), 32'd0);
    check("rst_ovf", 32'(overflow_out), 32'd0);
    check("rst_full", 32'(full_out), 32'd1);
    check("rst_afull", 32'(almost_full_out), 32'd0);
    rst = 1'b0;
    check("init_full_c1", 32'(full_out), 32'd1);
    step();
    check("init_full_c2", 32'(full_out), 32'd1);
    step();
    check("run_full", 32'(full_out), 32'd0);

    // Fill: 20 request cycles, 16 accepts
    for (int a = 0; a < 16; a++) exp_addr_q.push_back(4'(a));
    wr_req_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      k_sat = (k > 16) ? 16 : k;
      check("fill_full", 32'(full_out), 32'(k >= 16));
      check("fill_afull", 32'(almost_full_out), 32'(k >= 14));
      check("fill_level", 32'(level_out), 32'(k_sat));
      check("fill_ovf", 32'(overflow_out), 32'(k >= 17));
      step();
    end
    wr_req_in = 1'b0;
    check("fill_pulses", 32'(pulse_cnt), 32'd16);
    check("fill_gray", 32'(wr_gray_ptr_out), 32'b11000);
    check("fill_level_end", 32'(level_out), 32'd16);
    check("fill_full_end", 32'(full_out), 32'd1);
    check("fill_afull_end", 32'(almost_full_out), 32'd1);

    // Overflow while full
    wr_req_in = 1'b1;
    @(negedge Clk);
    check("ovf_wr_en", 32'(wr_en_out), 32'd0);
    step();
    wr_req_in = 1'b0;
    check("ovf_addr", 32'(wr_addr_out), 32'd0);
    check("ovf_gray", 32'(wr_gray_ptr_out), 32'b11000);
    check("ovf_flag", 32'(overflow_out), 32'd1);
    repeat (10) step();
    check("ovf_sticky", 32'(overflow_out), 32'd1);
    check("ovf_pulses", 32'(pulse_cnt), 32'd16);

    // Free space: read pointer moves to 4
    rd_gray_ptr_in = 5'b00110;
    step();
    check("free_full_e1", 32'(full_out), 32'd1);
    step();
    check("free_full_e2", 32'(full_out), 32'd1);
    step();
    check("free_full_e3", 32'(full_out), 32'd0);
    check("free_level", 32'(level_out), 32'd12);
    check("free_afull", 32'(almost_full_out), 32'd0);

    // Wrap: read pointer trails the write pointer by 2, 40 writes
    wb = 5'd16;
    prev_gray = wr_gray_ptr_out;
    gray_chk_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      exp_addr_q.push_back(wb[3:0]);
      rd_gray_ptr_in = g5(wb - 5'd2);
      wr_req_in = 1'b1;
      step();
      check("wrap_full", 32'(full_out), 32'd0);
      wb = wb + 5'd1;
    end
    wr_req_in = 1'b0;
    @(negedge Clk);
    gray_chk_en = 1'b0;
    check("wrap_addr", 32'(wr_addr_out), 32'd8);
    check("wrap_gray", 32'(wr_gray_ptr_out), 32'(g5(5'd24)));
    check("wrap_pulses", 32'(pulse_cnt), 32'd56);

    // Reset during the 5th write of a burst
    step();
    for (int a = 8; a < 12; a++) exp_addr_q.push_back(4'(a));
    wr_req_in = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    rd_gray_ptr_in = '0;
    step();
    check("mid_rst_gray", 32'(wr_gray_ptr_out), 32'd0);
    check("mid_rst_ovf", 32'(overflow_out), 32'd0);
    check("mid_rst_full", 32'(full_out), 32'd1);
    check("mid_rst_addr", 32'(wr_addr_out), 32'd0);
    rst = 1'b0;
    exp_addr_q.push_back(4'd0);
    @(negedge Clk);
    check("mid_init_wr_en_c1", 32'(wr_en_out), 32'd0);
    step();
    check("mid_init_full_c2", 32'(full_out), 32'd1);
    @(negedge Clk);
    check("mid_init_wr_en_c2", 32'(wr_en_out), 32'd0);
    step();
    check("mid_run_full", 32'(full_out), 32'd0);
    @(negedge Clk);
    check("mid_run_wr_en", 32'(wr_en_out), 32'd1);
    step();
    wr_req_in = 1'b0;
    check("mid_run_addr", 32'(wr_addr_out), 32'd1);
    check("mid_run_gray", 32'(wr_gray_ptr_out), 32'd1);
    step();
    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
